// File: rtl/reg_cmd_pkg.sv
// Shared constants for the register command parser: opcodes, FSM encoding, error causes.
package reg_cmd_pkg;

    typedef logic [1:0] opcode_t;
    typedef logic [1:0] state_t;
    typedef logic [1:0] err_code_t;

    localparam opcode_t OP_NOP   = 2'b00;
    localparam opcode_t OP_WRITE = 2'b01;
    localparam opcode_t OP_CLEAR = 2'b10;
    localparam opcode_t OP_RSVD  = 2'b11;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DATA  = 2'd1;
    localparam state_t ST_CHK   = 2'd2;
    localparam state_t ST_ISSUE = 2'd3;

    localparam err_code_t ERR_NONE = 2'b00;
    localparam err_code_t ERR_CHK  = 2'b01;
    localparam err_code_t ERR_ADDR = 2'b10;
    localparam err_code_t ERR_OP   = 2'b11;

endpackage

// File: rtl/reg_cmd_parser_xor_accum.sv
// 8-bit running XOR of accepted frame bytes; clear wins over enable.
module xor_accum (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc ^ din;
    end

endmodule

// File: rtl/reg_cmd_parser.sv
// Byte-stream command parser: decodes header/payload/checksum frames into
// per-register write and clear strobes.
module reg_cmd_parser
    import reg_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_REGS     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [N_REGS-1:0]     o_reg_wr,
    output logic [N_REGS-1:0]     o_reg_clr,
    output logic [DATA_WIDTH-1:0] o_reg_data,
    output logic                  o_err,
    output logic [1:0]            o_err_code
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t                state;
    opcode_t               op;
    logic [5:0]            addr;
    logic [CW-1:0]         byte_cnt;
    logic [DATA_WIDTH-1:0] payload;
    logic [7:0]            acc;
    logic [N_REGS-1:0]     sel;
    logic                  rx_acc;
    logic                  addr_ok;
    logic                  hdr_rsvd;

    assign o_rx_ready = (state != ST_ISSUE);
    assign rx_acc     = i_rx_valid & o_rx_ready;
    assign addr_ok    = ({1'b0, addr} < 7'(N_REGS));
    assign hdr_rsvd   = rx_acc && (state == ST_IDLE) && (i_rx_data[7:6] == OP_RSVD);

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REGS; i++)
            sel[i] = (addr == 6'(i));
    end

    // Header and payload feed the XOR; a rejected reserved header restarts it.
    xor_accum u_xor_accum (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .clr      ((state == ST_ISSUE) || hdr_rsvd),
        .en       (rx_acc && (state == ST_IDLE || state == ST_DATA)),
        .din      (i_rx_data),
        .acc      (acc)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= ST_IDLE;
            op         <= OP_NOP;
            addr       <= '0;
            byte_cnt   <= '0;
            payload    <= '0;
            o_reg_wr   <= '0;
            o_reg_clr  <= '0;
            o_reg_data <= '0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
        end else begin
            o_reg_wr  <= '0;
            o_reg_clr <= '0;
            o_err     <= 1'b0;
            case (state)
                ST_IDLE: if (rx_acc) begin
                    op       <= i_rx_data[7:6];
                    addr     <= i_rx_data[5:0];
                    byte_cnt <= '0;
                    case (i_rx_data[7:6])
                        OP_WRITE: state <= ST_DATA;
                        OP_RSVD: begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_OP;
                        end
                        default:  state <= ST_CHK;
                    endcase
                end
                ST_DATA: if (rx_acc) begin
                    payload <= (payload << 8) | DATA_WIDTH'(i_rx_data);
                    if (byte_cnt == CW'(NBYTES - 1)) begin
                        byte_cnt <= '0;
                        state    <= ST_CHK;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                // Strobes are registered here so they appear in the ISSUE cycle.
                ST_CHK: if (rx_acc) begin
                    state <= ST_ISSUE;
                    if (i_rx_data != acc) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_CHK;
                    end else if (!addr_ok) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_ADDR;
                    end else if (op == OP_WRITE) begin
                        o_reg_wr   <= sel;
                        o_reg_data <= payload;
                    end else if (op == OP_CLEAR) begin
                        o_reg_clr  <= sel;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
